// File: rtl/encoder8_3_serial_pkg.sv
// Shared widths and FSM state type for the serializing 8-to-3 encoder.
package encoder_pkg;
  localparam int DATA_W = 8;
  localparam int CODE_W = 3;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_e;
endpackage

// File: rtl/encoder8_3_serial_if.sv
// Input word and output code handshakes of encoder8_3_serial.
interface encoder8_3_serial_if;
  import encoder_pkg::*;

  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [CODE_W-1:0] out_code;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;
  logic              out_zero;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_code, out_valid, out_last, out_zero
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_code, out_valid, out_last, out_zero
  );
endinterface

// File: rtl/encoder8_3_serial_pri_enc8.sv
// Combinational 8-bit priority encoder with selectable scan direction.
module pri_enc8
  import encoder_pkg::*;
(
  input  logic [DATA_W-1:0] vec_i,
  input  logic              lsb_first_i,
  output logic [CODE_W-1:0] idx_o,
  output logic              any_o,
  output logic              single_o
);

  always_comb begin
    idx_o = '0;
    if (lsb_first_i) begin
      // Walk downward so the lowest set bit is written last and wins.
      for (int i = DATA_W - 1; i >= 0; i--) begin
        if (vec_i[i]) idx_o = CODE_W'(i);
      end
    end else begin
      for (int i = 0; i < DATA_W; i++) begin
        if (vec_i[i]) idx_o = CODE_W'(i);
      end
    end
  end

  assign any_o    = |vec_i;
  assign single_o = any_o && ((vec_i & (vec_i - DATA_W'(1))) == '0);

endmodule

// File: rtl/encoder8_3_serial.sv
// Serializing 8-to-3 encoder: one 3-bit code per set bit of an accepted word.
// Optional ENCODER_ZERO_FLAG_EN emits a single flagged beat for an all-zero word.
module encoder8_3_serial
  import encoder_pkg::*;
#(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  encoder8_3_serial_if.slave  bus
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] pend_q,  pend_d;

  logic [CODE_W-1:0] enc_idx;
  logic              enc_any;
  logic              enc_single;
  logic              last_w;

  pri_enc8 u_pri_enc8 (
    .vec_i       (pend_q),
    .lsb_first_i (LSB_FIRST),
    .idx_o       (enc_idx),
    .any_o       (enc_any),
    .single_o    (enc_single)
  );

  // An empty pend while in SCAN can only be the zero-word beat.
  assign last_w = enc_single || !enc_any;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pend_d        = pend_q;
    bus.in_ready  = (state_q == IDLE);
    bus.out_valid = (state_q == SCAN);
    bus.out_code  = enc_idx;
    bus.out_last  = (state_q == SCAN) && last_w;
`ifdef ENCODER_ZERO_FLAG_EN
    bus.out_zero  = (state_q == SCAN) && !enc_any;
`else
    bus.out_zero  = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          pend_d = bus.in_data;
`ifdef ENCODER_ZERO_FLAG_EN
          state_d = SCAN;
`else
          if (bus.in_data != '0) state_d = SCAN;
`endif
        end
      end
      SCAN: begin
        if (bus.out_ready) begin
          if (enc_any) pend_d = pend_q & ~(DATA_W'(1) << enc_idx);
          if (last_w)  state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_encoder8_3_serial.sv
// Bench for encoder8_3_serial: LSB-first and MSB-first instances share stimulus
// and are checked every cycle against a queue-of-codes model.
module tb_encoder8_3_serial;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  encoder8_3_serial_if bus1 ();
  encoder8_3_serial_if bus0 ();

  encoder8_3_serial #(.LSB_FIRST(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  encoder8_3_serial #(.LSB_FIRST(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));

`ifdef ENCODER_ZERO_FLAG_EN
  localparam bit ZF = 1'b1;
`else
  localparam bit ZF = 1'b0;
`endif

  // Model: per instance, the codes still to be emitted; 8 marks a zero-word beat.
  int q1[$];
  int q0[$];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      q1.delete();
      q0.delete();
    end else begin
      if (q1.size() == 0) begin
        if (bus1.in_valid) begin
          for (int i = 0; i < 8; i++) if (bus1.in_data[i]) q1.push_back(i);
          for (int i = 7; i >= 0; i--) if (bus1.in_data[i]) q0.push_back(i);
          if (bus1.in_data == 8'h00 && ZF) begin
            q1.push_back(8);
            q0.push_back(8);
          end
        end
      end else if (bus1.out_ready) begin
        void'(q1.pop_front());
        void'(q0.pop_front());
      end
    end
  end

  int n_chk  = 0;
  int n_pass = 0;
  int log1[$];
  int log0[$];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic cmp_one(input string tag, input int q[$], input logic v, input logic r,
                         input logic [2:0] c, input logic l, input logic z);
    chk({tag, "_out_valid"}, int'(v), int'(q.size() != 0));
    chk({tag, "_in_ready"},  int'(r), int'(q.size() == 0));
    if (q.size() != 0) begin
      chk({tag, "_out_code"}, int'(c), (q[0] == 8) ? 0 : q[0]);
      chk({tag, "_out_last"}, int'(l), int'(q.size() == 1));
      chk({tag, "_out_zero"}, int'(z), int'(q[0] == 8));
    end else begin
      chk({tag, "_out_zero_idle"}, int'(z), 0);
    end
  endtask

  task automatic check_log(input string name, input int got[$], input int exp[$]);
    chk({name, "_count"}, got.size(), exp.size());
    for (int i = 0; i < got.size() && i < exp.size(); i++)
      chk($sformatf("%s_code%0d", name, i), got[i], exp[i]);
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic r);
    bus1.in_valid = v; bus1.in_data = d; bus1.out_ready = r;
    bus0.in_valid = v; bus0.in_data = d; bus0.out_ready = r;
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(bus1.in_ready && bus0.in_ready) && n < 40) begin
      edge1();
      n++;
    end
    chk("wait_idle_timeout", int'(n >= 40), 0);
  endtask

  // Accept one word (caller has the block idle), then drain with out_ready=1.
  task automatic run_word(input logic [7:0] w);
    log1.delete();
    log0.delete();
    drive(1'b1, w, 1'b1);
    edge1();
    drive(1'b0, 8'h00, 1'b1);
    wait_idle();
  endtask

  initial begin
    drive(1'b0, 8'h00, 1'b1);
    fork
      forever begin
        @(negedge clk);
        cmp_one("lsb", q1, bus1.out_valid, bus1.in_ready, bus1.out_code, bus1.out_last, bus1.out_zero);
        cmp_one("msb", q0, bus0.out_valid, bus0.in_ready, bus0.out_code, bus0.out_last, bus0.out_zero);
        if (rst && bus1.out_valid && bus1.out_ready) log1.push_back(int'(bus1.out_code));
        if (rst && bus0.out_valid && bus0.out_ready) log0.push_back(int'(bus0.out_code));
      end
    join_none

    // 1: reset state, then a one-hot word
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    chk("rst_in_ready", int'(bus1.in_ready), 1);
    chk("rst_out_valid", int'(bus1.out_valid), 0);
    chk("rst_out_code", int'(bus1.out_code), 0);
    chk("rst_out_last", int'(bus1.out_last), 0);
    chk("rst_out_zero", int'(bus1.out_zero), 0);
    log1.delete();
    log0.delete();
    drive(1'b1, 8'h20, 1'b1);
    edge1();
    drive(1'b0, 8'h00, 1'b1);
    chk("t1_valid", int'(bus1.out_valid), 1);
    chk("t1_code", int'(bus1.out_code), 5);
    chk("t1_last", int'(bus1.out_last), 1);
    edge1();
    chk("t1_ready_back", int'(bus1.in_ready), 1);
    check_log("t1_lsb", log1, '{5});

    // 2: multi-hot in both scan orders
    run_word(8'b1010_0110);
    check_log("t2_lsb", log1, '{1, 2, 5, 7});
    check_log("t2_msb", log0, '{7, 5, 2, 1});

    // 3: backpressure holds the head code
    log1.delete();
    log0.delete();
    drive(1'b1, 8'h81, 1'b0);
    edge1();
    drive(1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("t3_hold_code_lsb", int'(bus1.out_code), 0);
      chk("t3_hold_code_msb", int'(bus0.out_code), 7);
      chk("t3_hold_in_ready", int'(bus1.in_ready), 0);
      edge1();
    end
    drive(1'b0, 8'h00, 1'b1);
    wait_idle();
    check_log("t3_lsb", log1, '{0, 7});
    check_log("t3_msb", log0, '{7, 0});

    // 4: zero word
    log1.delete();
    log0.delete();
    drive(1'b1, 8'h00, 1'b1);
    edge1();
    drive(1'b0, 8'h00, 1'b1);
    chk("t4_valid", int'(bus1.out_valid), int'(ZF));
    chk("t4_zero", int'(bus1.out_zero), int'(ZF));
    chk("t4_in_ready", int'(bus1.in_ready), int'(!ZF));
    wait_idle();
    if (ZF) check_log("t4_lsb", log1, '{0});
    else    check_log("t4_lsb", log1, '{});

    // 5: reset in the middle of a scan
    log1.delete();
    log0.delete();
    drive(1'b1, 8'hFF, 1'b1);
    edge1();
    drive(1'b0, 8'h00, 1'b1);
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("t5_valid_drop_lsb", int'(bus1.out_valid), 0);
    chk("t5_valid_drop_msb", int'(bus0.out_valid), 0);
    check_log("t5_before_rst", log1, '{0, 1, 2});
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    chk("t5_in_ready", int'(bus1.in_ready), 1);
    run_word(8'h02);
    check_log("t5_after_lsb", log1, '{1});
    check_log("t5_after_msb", log0, '{1});

    // 6: in_valid held across two words
    log1.delete();
    log0.delete();
    drive(1'b1, 8'h03, 1'b1);
    edge1();
    drive(1'b1, 8'h40, 1'b1);
    edge1();
    edge1();
    chk("t6_gap_ready", int'(bus1.in_ready), 1);
    chk("t6_gap_valid", int'(bus1.out_valid), 0);
    edge1();
    drive(1'b0, 8'h00, 1'b1);
    chk("t6_code6", int'(bus1.out_code), 6);
    chk("t6_last6", int'(bus1.out_last), 1);
    wait_idle();
    check_log("t6_lsb", log1, '{0, 1, 6});
    check_log("t6_msb", log0, '{1, 0, 6});

    // Random traffic, checked by the per-cycle compare
    for (int i = 0; i < 600; i++) begin
      logic [7:0] w;
      w = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      drive(1'($urandom), w, $urandom_range(0, 3) != 0);
      edge1();
    end
    drive(1'b0, 8'h00, 1'b1);
    wait_idle();
    edge1();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/encoder8_3_serial.md
# encoder8_3_serial

Serializing 8-to-3 encoder, the transmit-side counterpart of the 3-to-8 decoder: converts an 8-bit multi-hot event word into a stream of 3-bit line codes, one per set bit. It sits between event/interrupt sources and the decoder path. The input side and the output side each use a valid/ready handshake.

## Interface

- LSB_FIRST, 1, scan order:
  - 1 emits the lowest set bit first.
  - 0 emits the highest set bit first.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset (asserts immediately, deasserts synchronously to clk by the source).
- in_data  in  8  event word, one bit per line.
- in_valid  in  1  in_data is valid this cycle.
- in_ready  out  1  block can accept a word.
- out_code  out  3  binary index of the line being emitted.
- out_valid  out  1  out_code, out_last and out_zero are valid.
- out_ready  in  1  downstream accepts the current code.
- out_last  out  1  current code is the final one for the captured word.
- out_zero  out  1  current beat reports an all-zero word (ENCODER_ZERO_FLAG_EN only; otherwise tied 0).

## Operation

- States: IDLE, SCAN. A pending register `pend[7:0]` holds the bits not yet emitted.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid&&in_ready, pend<=in_data.
  - Nonzero word -> SCAN.
  - Zero word -> see Configuration.
- SCAN:
  - in_ready=0, out_valid=1.
  - out_code = index of the first set bit of pend in LSB_FIRST order.
  - out_last = 1 iff pend has exactly one bit set.
- Transfer: out_valid&&out_ready.
  - On a transfer, the emitted bit is cleared in pend.
  - If out_last, the next state is IDLE; otherwise the block stays in SCAN.
- Backpressure: while out_ready=0, pend, out_code and out_last hold stable.
- Input changes are ignored outside IDLE; there is no input buffering.
- Word 8'hFF yields 8 codes:
  - LSB_FIRST=1: 0..7.
  - LSB_FIRST=0: 7..0.

## Timing

- Reset values: state=IDLE, pend=0, out_valid=0, out_code=0, out_last=0, out_zero=0, in_ready=1.
- Latency: a word accepted at edge N gives out_valid=1 from cycle N+1.
- Throughput:
  - One code per cycle with out_ready held at 1.
  - A word with k set bits occupies 1 accept cycle + k output cycles.
  - in_ready returns on the cycle after the last transfer. There is no accept/emit overlap.
- out_code, out_last and out_zero are combinational from the registered pend/state. They are glitch-free relative to clk and have no input-to-output combinational path.
- Reset mid-scan: pend is discarded and out_valid drops asynchronously. After reset release the block is in IDLE with in_ready=1.
- in_valid held high across a word: exactly one capture per IDLE visit.

## Configuration

- Macro `ENCODER_ZERO_FLAG_EN`.
- Defined:
  - An accepted all-zero word enters SCAN for exactly one beat with out_code=0, out_zero=1, out_last=1.
  - That beat completes on out_ready, then the block returns to IDLE.
- Undefined:
  - An accepted all-zero word is consumed and dropped; the block stays in IDLE with no output beat.
  - The out_zero port remains and is tied 0.

## Structure

- Package `encoder_pkg`:
  - DATA_W=8, CODE_W=3.
  - State enum (IDLE, SCAN).
- Sub-module `pri_enc8`, purely combinational:
  - Inputs: 8-bit vector, order select.
  - Outputs: 3-bit index, any-set flag, single-bit flag.
  - Instantiated once on pend.
- Top block holds the FSM, the pend register and the handshake logic.

## Test plan

1. Reset and one-hot input:
   - Stimulus: hold rst=0 for 2 cycles, release, send in_data=8'h20 with out_ready=1.
   - Required: in_ready=1 after reset; one beat out_code=5, out_last=1 on the cycle after accept; in_ready=1 again on the following cycle.
2. Multi-hot, LSB_FIRST=1:
   - Stimulus: in_data=8'b1010_0110 with out_ready=1.
   - Required: codes 1,2,5,7 on consecutive cycles, out_last only on 7.
   - Repeat with LSB_FIRST=0: codes 7,5,2,1.
3. Backpressure:
   - Stimulus: in_data=8'h81, out_ready=0 for 3 cycles, then 1.
   - Required: out_code=0 held stable for 3 cycles with in_ready=0; then 0, 7 transfer, out_last on 7.
4. Zero word:
   - Stimulus: in_data=8'h00.
   - With ENCODER_ZERO_FLAG_EN: one beat, out_code=0, out_zero=1, out_last=1.
   - Without: no out_valid, and in_ready stays 1.
5. Reset mid-scan:
   - Stimulus: send 8'hFF, pull rst low after the third code.
   - Required: out_valid=0 immediately. After release in_ready=1, and a new 8'h02 emits only code 1.
6. Back-to-back words:
   - Stimulus: in_valid held with 8'h03 then 8'h40.
   - Required: codes 0, 1 (last), one idle/accept cycle, then code 6 (last).
